mat_vec_engine: RTL and testbench

- Parametrised matrix-vector multiply engine. It fetches one vector and ROWS matrix rows from a word-wide read-only memory, then computes ROWS dot products in parallel (one MAC per row) over COLS cycles.
- It adds three capabilities beyond a fixed 8x8 controller:
  - start/busy/done handshake
  - runtime base address
  - optional accumulation across runs
- Sits between the on-chip memory read port and downstream result consumers.

---
 rtl/mat_vec_engine.sv | 113 +++++++++++
 tb/tb_mat_vec_engine.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mat_vec_engine.sv
// mat_vec_engine: fetches a vector and ROWS matrix rows from word-wide memory,
// then runs ROWS parallel MACs over COLS cycles with optional accumulation.
module mat_vec_engine #(
    parameter int DATA_W = 8,
    parameter int ROWS = 8,
    parameter int COLS = 8,
    parameter int ACC_W = 24,
    parameter int ADDR_W = 32,
    localparam int IW = ROWS > 1 ? $clog2(ROWS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic                     acc_mode,
    output logic                     busy,
    output logic                     done,
    output logic                     mem_read,
    output logic [ADDR_W-1:0]        mem_address,
    input  logic                     mem_waitrequest,
    input  logic [COLS*DATA_W-1:0]   mem_readdata,
    input  logic                     mem_readdatavalid,
    input  logic [IW-1:0]            res_idx,
    output logic [ACC_W-1:0]         res_data
);
    localparam int KW = $clog2(ROWS + 1);
    localparam int CW = COLS > 1 ? $clog2(COLS) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, CALC, DONE} state_t;

    state_t state, state_n;
    logic [ADDR_W-1:0] base;
    logic [KW-1:0] k;
    logic [CW-1:0] c;
    logic pend, got;
    logic [COLS*DATA_W-1:0] vec;
    logic [COLS*DATA_W-1:0] row [ROWS];
    logic [ACC_W-1:0] acc [ROWS];
    logic [2*DATA_W-1:0] prod [ROWS];

    assign got = state == FETCH && pend && mem_readdatavalid;

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_n;

    always_comb
        state_n = (state == IDLE && start) ? FETCH :
                  (got && k == KW'(ROWS)) ? CALC :
                  (state == CALC && c == CW'(COLS - 1)) ? DONE :
                  (state == DONE) ? IDLE : state;

    always_comb begin
        busy = state != IDLE;
        done = state == DONE;
    end

    // full-width product so the ACC_W cast only zero-extends or truncates
    always_comb
        for (int r = 0; r < ROWS; r++)
            prod[r] = {{DATA_W{1'b0}}, row[r][c*DATA_W +: DATA_W]} * {{DATA_W{1'b0}}, vec[c*DATA_W +: DATA_W]};

    always_comb
        res_data = (int'(res_idx) < ROWS) ? acc[res_idx] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_read <= 1'b0;
            mem_address <= '0;
            base <= '0;
            k <= '0;
            c <= '0;
            pend <= 1'b0;
            vec <= '0;
            for (int r = 0; r < ROWS; r++) begin
                row[r] <= '0;
                acc[r] <= '0;
            end
        end else begin
            if (state == IDLE && start) begin
                base <= base_addr;
                k <= '0;
                c <= '0;
                mem_read <= 1'b1;
                mem_address <= base_addr;
                if (!acc_mode)
                    for (int r = 0; r < ROWS; r++)
                        acc[r] <= '0;
            end
            if (state == FETCH && mem_read && !mem_waitrequest) begin
                mem_read <= 1'b0;
                pend <= 1'b1;
            end
            if (got) begin
                pend <= 1'b0;
                if (k == '0)
                    vec <= mem_readdata;
                for (int r = 0; r < ROWS; r++)
                    if (k == KW'(r + 1))
                        row[r] <= mem_readdata;
                if (k != KW'(ROWS)) begin
                    k <= k + KW'(1);
                    mem_read <= 1'b1;
                    mem_address <= base + ADDR_W'(k) + ADDR_W'(1);
                end
            end
            if (state == CALC) begin
                c <= c + CW'(1);
                for (int r = 0; r < ROWS; r++)
                    acc[r] <= acc[r] + ACC_W'(prod[r]);
            end
        end
    end
endmodule

// File: tb/tb_mat_vec_engine.sv
// tb_mat_vec_engine: randomized memory model with latency/stalls and a
// plain-arithmetic dot-product reference, checking 24- and 16-bit accumulators.
module tb_mat_vec_engine;
    localparam int DW = 8, R = 8, C = 8, AW = 32, W = C * DW;

    logic clk = 0, rst, start, acc_mode, wr, rdv;
    logic busy, done, mem_read, busy16, done16, mem_read16;
    logic [AW-1:0] base_addr, mem_address, mem_address16;
    logic [W-1:0] rdata;
    logic [2:0] res_idx;
    logic [23:0] res24;
    logic [15:0] res16;

    mat_vec_engine #(.DATA_W(DW), .ROWS(R), .COLS(C), .ACC_W(24), .ADDR_W(AW)) u24 (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .acc_mode(acc_mode),
        .busy(busy), .done(done), .mem_read(mem_read), .mem_address(mem_address),
        .mem_waitrequest(wr), .mem_readdata(rdata), .mem_readdatavalid(rdv),
        .res_idx(res_idx), .res_data(res24));

    mat_vec_engine #(.DATA_W(DW), .ROWS(R), .COLS(C), .ACC_W(16), .ADDR_W(AW)) u16 (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .acc_mode(acc_mode),
        .busy(busy16), .done(done16), .mem_read(mem_read16), .mem_address(mem_address16),
        .mem_waitrequest(wr), .mem_readdata(rdata), .mem_readdatavalid(rdv),
        .res_idx(res_idx), .res_data(res16));

    always #5 clk = ~clk;

    logic [W-1:0] mem [logic [AW-1:0]];
    longint ref24 [R], ref16 [R];
    int nvec = 0, nerr = 0;
    int lat = 1, pend_cnt = 0, stall_left = 0, stalls = 0, n_acc = 0;
    logic rnd = 0, spur = 0, st, prev_stall = 0, prev_acc = 0;
    logic [AW-1:0] stall_addr = '1, exp_base = '0, prev_addr = '0, rd_addr = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // memory: L-cycle read latency, directed or random waitrequest, optional spurious valids
    initial begin
        wr = 0; rdv = 0; rdata = '0;
        forever begin
            @(negedge clk);
            if (prev_stall) begin
                chk("stall_read", mem_read, 1);
                chk("stall_addr", mem_address, prev_addr);
            end
            if (prev_acc) chk("read_drop", mem_read, 0);
            rdv = 0;
            rdata = {$urandom, $urandom};
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    rdv = 1;
                    rdata = mem[rd_addr];
                end
            end else if (spur && $urandom_range(0, 3) == 0) rdv = 1;
            st = mem_read && stall_left > 0 && mem_address == stall_addr;
            if (st) stall_left--;
            wr = st || (mem_read && rnd && $urandom_range(0, 2) == 0);
            if (mem_read && wr) stalls++;
            prev_stall = mem_read && wr;
            prev_addr = mem_address;
            prev_acc = mem_read && !wr;
            if (prev_acc) begin
                chk("addr", mem_address, exp_base + AW'(n_acc));
                chk("addr16", mem_address16, exp_base + AW'(n_acc));
                rd_addr = mem_address;
                pend_cnt = lat;
                n_acc++;
            end
        end
    end

    task automatic fill(input logic [AW-1:0] b, input int mode);
        logic [W-1:0] w;
        for (int a = 0; a <= R; a++) begin
            for (int c = 0; c < C; c++)
                w[c*DW +: DW] = mode == 0 ? DW'(a == 0 ? 1 : a) : mode == 1 ? DW'(255) : DW'($urandom);
            mem[b + AW'(a)] = w;
        end
    endtask

    task automatic chk_res(input string tag);
        for (int r = 0; r < R; r++) begin
            res_idx = 3'(r);
            #1;
            chk({tag, "24"}, res24, ref24[r]);
            chk({tag, "16"}, res16, ref16[r]);
        end
    endtask

    task automatic run(input logic [AW-1:0] b, input logic m, input int l,
                       input logic [AW-1:0] sa, input int sn, input logic r_, input logic pulses);
        int cyc;
        longint s;
        logic [W-1:0] v, w;
        v = mem[b];
        for (int r = 0; r < R; r++) begin
            w = mem[b + AW'(1 + r)];
            s = 0;
            for (int c = 0; c < C; c++)
                s += longint'(w[c*DW +: DW]) * longint'(v[c*DW +: DW]);
            ref24[r] = ((m ? ref24[r] : 0) + s) % 64'd16777216;
            ref16[r] = ((m ? ref16[r] : 0) + s) % 64'd65536;
        end
        @(negedge clk);
        lat = l; stall_addr = sa; stall_left = sn; rnd = r_;
        stalls = 0; n_acc = 0; exp_base = b;
        base_addr = b; acc_mode = m; start = 1;
        @(negedge clk);
        start = 0; base_addr = $urandom; acc_mode = 1'($urandom);
        cyc = 1;
        chk("first_read", mem_read, 1);
        while (!done && cyc < 3000) begin
            chk("busy", busy, 1);
            chk("busy16", busy16, 1);
            if (pulses) start = 1'($urandom_range(0, 1));
            @(negedge clk);
            start = 0;
            cyc++;
        end
        chk("done_cycle", cyc, 1 + (R + 1) * (l + 1) + C + stalls);
        chk("done16", done16, 1);
        chk("reads", n_acc, R + 1);
        chk_res("res");
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk_res("hold");
    endtask

    initial begin
        rst = 1; start = 0; acc_mode = 0; base_addr = '0; res_idx = '0;
        for (int r = 0; r < R; r++) begin ref24[r] = 0; ref16[r] = 0; end
        repeat (3) @(negedge clk);
        rst = 0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_read", mem_read, 0);
        chk("rst_addr", mem_address, 0);
        chk_res("rst");

        fill(32'h100, 0);
        run(32'h100, 0, 1, '1, 0, 0, 0);
        for (int r = 0; r < R; r++) chk("basic_val", ref24[r], 8 * (r + 1));
        run(32'h100, 1, 1, '1, 0, 0, 0);
        run(32'h100, 0, 1, '1, 0, 0, 0);
        fill(32'h300, 1);
        run(32'h300, 0, 1, '1, 0, 0, 0);
        fill(32'h100, 0);
        run(32'h100, 0, 1, 32'h104, 3, 0, 1);

        spur = 1;
        for (int i = 0; i < 10; i++) begin
            logic [AW-1:0] b;
            b = AW'($urandom_range(0, 1 << 20));
            fill(b, 2);
            run(b, 1'($urandom_range(0, 1)), $urandom_range(1, 4),
                b + AW'($urandom_range(0, R)), $urandom_range(0, 3), 1, 1);
        end
        spur = 0;

        begin
            int cnt;
            fill(32'h200, 2);
            @(negedge clk);
            lat = 3; rnd = 0; stall_left = 0; n_acc = 0; exp_base = 32'h200;
            base_addr = 32'h200; acc_mode = 1; start = 1;
            @(negedge clk);
            start = 0;
            cnt = 0;
            while (n_acc < 4 && cnt < 200) begin
                @(negedge clk);
                cnt++;
            end
            chk("k3_reached", n_acc, 4);
            rst = 1;
            @(negedge clk);
            rst = 0;
            for (int r = 0; r < R; r++) begin ref24[r] = 0; ref16[r] = 0; end
            chk("rst_mid_busy", busy, 0);
            chk("rst_mid_read", mem_read, 0);
            chk_res("rst_mid");
            repeat (6) begin
                @(negedge clk);
                chk("late_valid_busy", busy, 0);
            end
            chk_res("late_valid");
        end

        fill(32'h100, 0);
        run(32'h100, 1, 2, '1, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
